// File: rtl/dpr16_pkg.sv
// Shared constants for the DPR16X4C-based FIFO: RAM geometry and counter widths.
package dpr16_pkg;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int CW      = 5;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/dpr16_ram_slice.sv
// One 16x4 distributed-RAM slice with DPR16X4C behaviour: synchronous write on wck,
// asynchronous read of the word at rad. The read port is named dout because "do" is reserved.
module dpr16_ram_slice
  import dpr16_pkg::*;
(
  input  logic               wck,
  input  logic               wre,
  input  logic [SLICE_W-1:0] di,
  input  logic [AW-1:0]      wad,
  input  logic [AW-1:0]      rad,
  output logic [SLICE_W-1:0] dout
);

  logic [SLICE_W-1:0] mem [DEPTH];

  always_ff @(posedge wck)
    if (wre) mem[wad] <= di;

  assign dout = mem[rad];

endmodule

// File: rtl/dpr16_sync_fifo.sv
// Single-clock 16-deep FIFO over WIDTH/4 parallel DPR16X4C slices, with a registered
// read stage, occupancy count, level flags and sticky overflow/underflow.
module dpr16_sync_fifo
  import dpr16_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int NSLICE = WIDTH / SLICE_W;

  if (WIDTH % SLICE_W != 0 || WIDTH <= 0) begin : g_bad_width
    $error("dpr16_sync_fifo: WIDTH must be a positive multiple of 4");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("dpr16_sync_fifo: AFULL_LEVEL must be in 1..16");
  end

  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [NSLICE-1:0][SLICE_W-1:0]  ram_do;
  logic                            push_ok, pop_ok;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_LEVEL));

  // A full FIFO can still take a push when the same cycle frees a slot.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    dpr16_ram_slice u_slice (
      .wck  (clk),
      .wre  (push_ok),
      .di   (wr_data[g*SLICE_W +: SLICE_W]),
      .wad  (wr_ptr),
      .rad  (rd_ptr),
      .dout (ram_do[g])
    );
  end

  // rd_data samples DO before the same-edge write lands, so a push/pop on a
  // shared address returns the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= ram_do;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en & full & ~pop_ok) overflow  <= 1'b1;
      if (rd_en & empty)          underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpr16_sync_fifo.sv
// Directed bench for dpr16_sync_fifo (WIDTH=8): a queue model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_dpr16_sync_fifo;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_valid, full, almost_full, empty, overflow, underflow;
  logic [4:0]   count;

  int errors = 0;
  int checks = 0;

  dpr16_sync_fifo #(.WIDTH(W), .AFULL_LEVEL(14)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy is simply the queue length.
  logic [W-1:0] q[$];
  logic [W-1:0] m_rd_data  = '0;
  logic         m_rd_valid = 1'b0;
  logic         m_ovf      = 1'b0;
  logic         m_udf      = 1'b0;

  always @(negedge resetn) begin
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  end

  always @(posedge clk) begin
    if (resetn) begin
      automatic int  n   = q.size();
      automatic bit  pop = rd_en && n > 0;
      automatic bit  psh = wr_en && (n < 16 || pop);
      if (wr_en && n == 16 && !pop) m_ovf = 1'b1;
      if (rd_en && n == 0)          m_udf = 1'b1;
      m_rd_valid = pop;
      if (pop) m_rd_data = q.pop_front();
      if (psh) q.push_back(wr_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic int n = q.size();
    check("m.count",       32'(count),       32'(n));
    check("m.empty",       32'(empty),       32'(n == 0));
    check("m.full",        32'(full),        32'(n == 16));
    check("m.almost_full", 32'(almost_full), 32'(n >= 14));
    check("m.rd_valid",    32'(rd_valid),    32'(m_rd_valid));
    check("m.rd_data",     32'(rd_data),     32'(m_rd_data));
    check("m.overflow",    32'(overflow),    32'(m_ovf));
    check("m.underflow",   32'(underflow),   32'(m_udf));
  end

  // One clock: apply inputs, pass the rising edge, return at the falling edge.
  task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.data",  32'(rd_data),  32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // basic order
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    check("t1.count3", 32'(count), 32'd3);
    cyc(0, 0, 1); check("t1.d0", 32'({rd_valid, rd_data}), 32'h111);
    cyc(0, 0, 1); check("t1.d1", 32'({rd_valid, rd_data}), 32'h122);
    cyc(0, 0, 1); check("t1.d2", 32'({rd_valid, rd_data}), 32'h133);
    check("t1.empty", 32'({empty, count}), 32'h20);
    cyc(0, 0, 0); check("t1.hold", 32'({rd_valid, rd_data}), 32'h033);

    // fill, overflow, drain, wrap
    for (int i = 0; i < 16; i++) begin
      cyc(1, W'(i), 0);
      check("t2.afull", 32'(almost_full), 32'(i + 1 >= 14));
    end
    check("t2.full", 32'({full, count}), 32'h30);
    cyc(1, 8'hFF, 0);
    check("t2.ovf", 32'({overflow, count}), 32'h30);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      check("t2.drain", 32'(rd_data), 32'(i));
    end
    cyc(1, 8'hA5, 0);
    cyc(0, 0, 1); check("t2.wrap", 32'(rd_data), 32'hA5);

    // full with simultaneous push/pop
    for (int i = 0; i < 16; i++) cyc(1, W'(i), 0);
    cyc(1, 8'hEE, 1);
    check("t3.old", 32'({rd_valid, rd_data}), 32'h100);
    check("t3.count", 32'(count), 32'd16);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1);
      check("t3.drain", 32'(rd_data), 32'(i));
    end
    cyc(0, 0, 1); check("t3.last", 32'(rd_data), 32'hEE);

    // empty edge cases
    cyc(0, 0, 1);
    check("t4.udf", 32'({underflow, rd_valid}), 32'h2);
    cyc(1, 8'h5A, 1);
    check("t4.push_only", 32'({rd_valid, count}), 32'h01);
    cyc(0, 0, 1); check("t4.pop", 32'({rd_valid, rd_data}), 32'h15A);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, W'(8'h70 + i), 0);
    #2 resetn = 1'b0;
    #1;
    check("t5.count", 32'(count), 32'd0);
    check("t5.flags", 32'({empty, rd_valid, overflow, underflow}), 32'h8);
    check("t5.data",  32'(rd_data), 32'd0);
    @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    cyc(1, 8'h3C, 0);
    cyc(0, 0, 1); check("t5.after", 32'({rd_valid, rd_data}), 32'h13C);
    cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpr16_sync_fifo.md
Name: dpr16_sync_fifo

Overview:
- Single-clock 16-deep FIFO built on DPR16X4C distributed-RAM slices (WIDTH/4 slices in parallel).
- Sits directly upstream of a registered read stage: owns write/read address generation, WRE, flags, and the output register that captures the RAM's asynchronous DO.
- Provides the first real sequential consumer/producer around the DPR16X4C primitive, for timing characterisation and later reuse.

Parameters:
- WIDTH, 4, data width; must be a multiple of 4; elaboration error otherwise.
- AFULL_LEVEL, 14, count at or above which almost_full asserts; legal range 1..16.

Ports:
- clk  in  1  sole clock; drives RAM WCK and all registers.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- wr_data  in  WIDTH  push data.
- rd_en  in  1  pop request.
- rd_data  out  WIDTH  registered pop data.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  count == 16.
- almost_full  out  1  count >= AFULL_LEVEL.
- empty  out  1  count == 0.
- count  out  5  occupancy, 0..16.
- overflow  out  1  sticky: push attempted while full and not accepted.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (resetn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Outputs: empty=1, full=0, almost_full=0. RAM contents are undefined and are not cleared.
- Pointers are 4 bits and wrap 15->0 naturally.
- push_ok = wr_en & (~full | pop_ok). pop_ok = rd_en & ~empty.
- Pushing into a full FIFO is accepted only when a pop is accepted in the same cycle.
- Pop from an empty FIFO is never accepted, even with a simultaneous push.
- Write: WRE = push_ok, WAD = wr_ptr, DI = wr_data. The word lands on the clk rising edge and wr_ptr increments.
- Read: RAD = rd_ptr continuously. On pop_ok, rd_data <= DO at the rising edge, rd_ptr increments, and rd_valid=1 for exactly that following cycle.
- Latency: rd_en to rd_data/rd_valid is 1 cycle. Push to an empty FIFO clears empty 1 cycle later, so the earliest pop is in the cycle after the push.
- When no pop occurs, rd_data holds its last value and rd_valid=0.
- Simultaneous push+pop at the same address (full FIFO): the pop returns the OLD word, because the registered read samples DO before the write takes effect. The new word is stored.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds 16 and never goes below 0.
- Flags full, empty and almost_full are combinational decodes of registered count; they are glitch-free relative to clk.
- overflow sets when wr_en & full & ~pop_ok. underflow sets when rd_en & empty. Both clear only on reset.
- Reset asserted mid-operation: all state returns to reset values immediately. Stale RAM data is unreachable because the pointers restart at 0.

Decomposition:
- Shared package dpr16_pkg holds constants DEPTH=16, AW=4, CW=5, and SLICE_W=4.
- One sub-module: dpr16_ram_slice. It wraps a single DPR16X4C with vector ports di[3:0], wad[3:0], rad[3:0], do[3:0], wck, wre.
- The top level generates WIDTH/4 slice instances and contains the pointers, count, flags and output register.

Test Plan:
- Reset and basic order: with WIDTH=8, push 0x11,0x22,0x33 on consecutive cycles, then pop 3 consecutive cycles. Required: rd_data is 0x11,0x22,0x33, each with rd_valid, one cycle after the corresponding rd_en; count goes 0->3->0; empty returns to 1.
- Fill and wrap: push 16 words 0x00..0x0F. Required: full=1, count=16, almost_full asserted from count 14. A 17th push sets overflow=1 and leaves count at 16. Pop all 16 and read back 0x00..0x0F. Push 0xA5 and pop it; it comes out correctly via wr_ptr/rd_ptr wrap.
- Full plus simultaneous push/pop: from full (head 0x00), push 0xEE with rd_en. Required: rd_data=0x00, count stays 16, and 0xEE is the last word later popped.
- Empty edge cases: on an empty FIFO, rd_en alone sets underflow=1 and rd_valid stays 0. rd_en together with wr_en=0x5A: only the push is accepted, count=1, and the next-cycle pop returns 0x5A.
- Async reset mid-stream: push 5 words and drop resetn between clk edges. Required: count=0, empty=1, rd_valid=0, rd_data=0, and sticky flags clear immediately, without waiting for a clock edge. After release, push and pop 0x3C and read back 0x3C.
